// File: rtl/ndata_compactor_if.sv
// ndata_i: element-vector stream bundle shared by the compactor and its neighbours.
//   data  : NUM_ELEMENTS elements of data_t, element 0 in the low bits
//   keep  : per-element valid mask
//   last  : final beat of a packet
//   valid : beat offered by the master
//   ready : beat accepted by the slave
//   modport m drives the stream, modport s receives it.
interface ndata_i #(
  parameter type data_t = logic [7:0],
  parameter int NUM_ELEMENTS = 8
);
  data_t [NUM_ELEMENTS-1:0] data;
  logic [NUM_ELEMENTS-1:0] keep;
  logic last;
  logic valid;
  logic ready;
  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/ndata_compactor.sv
// ndata_compactor: squeezes keep-mask gaps out of a stream so beats leave dense and low-aligned.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   in  : ndata_i slave, any keep pattern (including all zero)
//   out : ndata_i master, full beats except the final beat of a packet
module ndata_compactor #(
  parameter type data_t = logic [7:0],
  parameter int NUM_ELEMENTS = 8
) (
  input logic clk,
  input logic rst,
  ndata_i.s in,
  ndata_i.m out
);
  localparam int N = NUM_ELEMENTS;
  localparam int B = 2 * N - 1;
  localparam int CW = $clog2(2 * N);
  if ($bits(in.keep) != N || $bits(out.keep) != N ||
      $bits(in.data) != N * $bits(data_t) || $bits(out.data) != N * $bits(data_t)) begin : g_bad_cfg
    $error("ndata_compactor: interface element count or element type mismatch");
  end
  data_t buf_q [B];
  data_t buf_d [B];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0] pos;
  logic pend_q, pend_d, full, in_fire, out_fire;
  assign full = cnt_q >= CW'(N);
  assign out.valid = full || pend_q;
  assign out.last = pend_q && cnt_q <= CW'(N);
  assign in.ready = !pend_q && (!full || out.ready);
  assign out_fire = out.valid && out.ready;
  assign in_fire = in.valid && in.ready;
  // keep bit i is set whenever more than i elements are buffered
  always_comb
    for (int i = 0; i < N; i++) begin
      out.data[i] = buf_q[i];
      out.keep[i] = cnt_q > CW'(i);
    end
  // pos walks the write slot: starts at the post-shift count, bumps once per kept element
  always_comb begin
    buf_d = buf_q;
    pend_d = pend_q;
    pos = {1'b0, cnt_q};
    if (out_fire) begin
      for (int j = 0; j < B - N; j++) buf_d[j] = buf_q[j + N];
      pos = full ? pos - (CW+1)'(N) : '0;
      if (out.last) pend_d = 1'b0;
    end
    if (in_fire) begin
      for (int i = 0; i < N; i++)
        if (in.keep[i]) begin
          if (pos < (CW+1)'(B)) buf_d[pos[CW-1:0]] = in.data[i];
          pos = pos + (CW+1)'(1);
        end
      if (in.last) pend_d = 1'b1;
    end
    cnt_d = pos[CW-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      assert (pos <= (CW+1)'(B)) else $error("ndata_compactor: buffer overflow");
      cnt_q <= cnt_d;
      pend_q <= pend_d;
    end
  always_ff @(posedge clk) buf_q <= buf_d;
endmodule

// File: tb/tb_ndata_compactor.sv
// tb_ndata_compactor: directed and random stimulus against an element/packet scoreboard.
module tb_ndata_compactor;
  localparam int N = 8;
  typedef logic [7:0] el_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done;
  int checks = 0;
  int failures = 0;
  int cur_len = 0;
  int out_cnt = 0;
  int n;
  el_t exp_q[$];
  int len_q[$];
  ndata_i #(.data_t(el_t), .NUM_ELEMENTS(N)) in_if ();
  ndata_i #(.data_t(el_t), .NUM_ELEMENTS(N)) out_if ();
  ndata_compactor #(.data_t(el_t), .NUM_ELEMENTS(N)) dut (
    .clk(clk),
    .rst(rst),
    .in(in_if),
    .out(out_if)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(logic [63:0] d, logic [7:0] k, logic l, logic v);
    in_if.data = d;
    in_if.keep = k;
    in_if.last = l;
    in_if.valid = v;
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  function automatic logic [63:0] seq(int base);
    logic [63:0] d;
    for (int i = 0; i < N; i++) d[8*i +: 8] = 8'(base + i);
    return d;
  endfunction
  // Scoreboard: kept input elements in order, plus the element count of every closed packet.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_q.delete();
      len_q.delete();
      cur_len = 0;
      out_cnt = 0;
    end else begin
      if (out_if.valid && out_if.ready) begin
        n = $countones(out_if.keep);
        chk("keep_contig", 64'(out_if.keep), 64'((1 << n) - 1));
        if (!out_if.last) chk("keep_full", 64'(out_if.keep), 64'hFF);
        for (int i = 0; i < n; i++) begin
          chk("elem_avail", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) chk("elem", 64'(out_if.data[i]), 64'(exp_q.pop_front()));
        end
        out_cnt += n;
        if (out_if.last) begin
          chk("pkt_known", 64'(len_q.size() > 0), 64'd1);
          if (len_q.size() > 0) chk("pkt_len", 64'(out_cnt), 64'(len_q.pop_front()));
          out_cnt = 0;
        end
      end
      if (in_if.valid && in_if.ready) begin
        for (int i = 0; i < N; i++)
          if (in_if.keep[i]) begin
            exp_q.push_back(in_if.data[i]);
            cur_len++;
          end
        if (in_if.last) begin
          len_q.push_back(cur_len);
          cur_len = 0;
        end
      end
    end
  end
  initial begin
    beat(64'd0, 8'h00, 1'b0, 1'b0);
    out_if.ready = 1'b1;
    #1;
    chk("rst_valid", 64'(out_if.valid), 64'd0);
    chk("rst_ready", 64'(in_if.ready), 64'd1);
    cyc(); cyc(); rst = 1'b0;
    // gapped keep across two beats collapses into one full last beat
    cyc(); beat(seq(0), 8'hAA, 1'b0, 1'b1); #1;
    chk("t1_ready", 64'(in_if.ready), 64'd1);
    chk("t1_nocomb", 64'(out_if.valid), 64'd0);
    cyc(); beat(seq(8), 8'hAA, 1'b1, 1'b1); #1;
    chk("t1_half", 64'(out_if.valid), 64'd0);
    cyc(); beat(64'd0, 8'h00, 1'b0, 1'b0); #1;
    chk("t1_valid", 64'(out_if.valid), 64'd1);
    chk("t1_data", out_if.data, 64'h0F0D0B0907050301);
    chk("t1_keep", 64'(out_if.keep), 64'hFF);
    chk("t1_last", 64'(out_if.last), 64'd1);
    chk("t1_block", 64'(in_if.ready), 64'd0);
    cyc(); #1;
    chk("t1_done", 64'(out_if.valid), 64'd0);
    chk("t1_reopen", 64'(in_if.ready), 64'd1);
    // sustained full beats
    for (int b = 0; b < 100; b++) begin
      cyc(); beat({$urandom, $urandom}, 8'hFF, b == 99, 1'b1); #1;
      chk("t2_ready", 64'(in_if.ready), 64'd1);
      if (b > 0) chk("t2_valid", 64'(out_if.valid), 64'd1);
    end
    cyc(); beat(64'd0, 8'h00, 1'b0, 1'b0); #1;
    chk("t2_tail_valid", 64'(out_if.valid), 64'd1);
    chk("t2_tail_last", 64'(out_if.last), 64'd1);
    cyc(); #1;
    chk("t2_idle", 64'(out_if.valid), 64'd0);
    // residue of 7 then a full last beat
    cyc(); beat(seq(16), 8'h7F, 1'b0, 1'b1); #1;
    chk("t3_ready", 64'(in_if.ready), 64'd1);
    cyc(); beat(seq(24), 8'hFF, 1'b1, 1'b1); #1;
    chk("t3_ready2", 64'(in_if.ready), 64'd1);
    chk("t3_wait", 64'(out_if.valid), 64'd0);
    cyc(); beat(64'd0, 8'h00, 1'b0, 1'b0); #1;
    chk("t3_b1_valid", 64'(out_if.valid), 64'd1);
    chk("t3_b1_keep", 64'(out_if.keep), 64'hFF);
    chk("t3_b1_last", 64'(out_if.last), 64'd0);
    chk("t3_b1_block", 64'(in_if.ready), 64'd0);
    cyc(); #1;
    chk("t3_b2_valid", 64'(out_if.valid), 64'd1);
    chk("t3_b2_keep", 64'(out_if.keep), 64'h7F);
    chk("t3_b2_last", 64'(out_if.last), 64'd1);
    chk("t3_b2_block", 64'(in_if.ready), 64'd0);
    cyc(); #1;
    chk("t3_idle", 64'(out_if.valid), 64'd0);
    chk("t3_reopen", 64'(in_if.ready), 64'd1);
    // empty last beat, then the next packet
    cyc(); beat(64'd0, 8'h00, 1'b1, 1'b1); #1;
    chk("t4_ready", 64'(in_if.ready), 64'd1);
    cyc(); beat(seq(32), 8'hFF, 1'b1, 1'b1); #1;
    chk("t4_valid", 64'(out_if.valid), 64'd1);
    chk("t4_keep", 64'(out_if.keep), 64'h00);
    chk("t4_last", 64'(out_if.last), 64'd1);
    chk("t4_block", 64'(in_if.ready), 64'd0);
    cyc(); #1;
    chk("t4_next_ready", 64'(in_if.ready), 64'd1);
    cyc(); beat(64'd0, 8'h00, 1'b0, 1'b0); #1;
    chk("t4_next_keep", 64'(out_if.keep), 64'hFF);
    chk("t4_next_last", 64'(out_if.last), 64'd1);
    cyc(); #1;
    chk("t4_idle", 64'(out_if.valid), 64'd0);
    // backpressure with 10 buffered
    cyc(); beat(seq(0), 8'h03, 1'b0, 1'b1); #1;
    cyc(); out_if.ready = 1'b0; beat(seq(10), 8'hFF, 1'b0, 1'b1); #1;
    chk("t5_fill_ready", 64'(in_if.ready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      cyc(); beat(seq(20), 8'h0F, 1'b1, 1'b1); #1;
      chk("t5_hold_ready", 64'(in_if.ready), 64'd0);
      chk("t5_hold_valid", 64'(out_if.valid), 64'd1);
      chk("t5_hold_data", out_if.data, 64'h0F0E0D0C0B0A0100);
      chk("t5_hold_keep", 64'(out_if.keep), 64'hFF);
      chk("t5_hold_last", 64'(out_if.last), 64'd0);
    end
    cyc(); out_if.ready = 1'b1; #1;
    chk("t5_release_ready", 64'(in_if.ready), 64'd1);
    cyc(); beat(64'd0, 8'h00, 1'b0, 1'b0); #1;
    chk("t5_tail_valid", 64'(out_if.valid), 64'd1);
    chk("t5_tail_keep", 64'(out_if.keep), 64'h3F);
    chk("t5_tail_last", 64'(out_if.last), 64'd1);
    chk("t5_tail_data", out_if.data & 64'h0000FFFFFFFFFFFF, 64'h0000171615141110);
    cyc(); #1;
    chk("t5_idle", 64'(out_if.valid), 64'd0);
    // asynchronous reset mid-packet
    cyc(); beat(seq(50), 8'h1F, 1'b0, 1'b1); #1;
    cyc(); out_if.ready = 1'b0; beat(seq(60), 8'hFF, 1'b0, 1'b1); #1;
    cyc(); beat(64'd0, 8'h00, 1'b0, 1'b0); #1;
    chk("t6_pre_valid", 64'(out_if.valid), 64'd1);
    rst = 1'b1; #1;
    chk("t6_rst_valid", 64'(out_if.valid), 64'd0);
    cyc(); cyc(); rst = 1'b0; out_if.ready = 1'b1;
    cyc(); beat(seq(70), 8'hFF, 1'b1, 1'b1); #1;
    chk("t6_ready", 64'(in_if.ready), 64'd1);
    cyc(); beat(64'd0, 8'h00, 1'b0, 1'b0); #1;
    chk("t6_valid", 64'(out_if.valid), 64'd1);
    chk("t6_data", out_if.data, seq(70));
    chk("t6_keep", 64'(out_if.keep), 64'hFF);
    chk("t6_last", 64'(out_if.last), 64'd1);
    cyc(); #1;
    chk("t6_idle", 64'(out_if.valid), 64'd0);
    // random traffic and backpressure
    for (int c = 0; c < 400; c++) begin
      cyc();
      beat({$urandom, $urandom}, ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
      out_if.ready = $urandom_range(0, 3) != 0;
    end
    cyc(); out_if.ready = 1'b1; beat({$urandom, $urandom}, 8'($urandom), 1'b1, 1'b1);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1 done = in_if.ready;
      cyc();
    end
    chk("t7_accept", 64'(done), 64'd1);
    beat(64'd0, 8'h00, 1'b0, 1'b0);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      cyc(); #3;
      done = exp_q.size() == 0 && len_q.size() == 0;
    end
    chk("t7_drain", 64'(done), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
